// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Flush beats hold, hold beats load-use; a bubble is the all-zero register image.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [DATA_W-1:0] readData1D,
  input  logic [DATA_W-1:0] readData2D,
  input  logic [DATA_W-1:0] immD,
  input  logic [DATA_W-1:0] pcPlus4D,
  input  logic              regWriteD,
  input  logic              memToRegD,
  input  logic              memReadD,
  input  logic              memWriteD,
  input  logic              aluSrcD,
  input  logic              regDstD,
  input  logic [3:0]        aluOpD,
  input  logic              flushE,
  input  logic              holdE,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [DATA_W-1:0] readData1E,
  output logic [DATA_W-1:0] readData2E,
  output logic [DATA_W-1:0] immE,
  output logic [DATA_W-1:0] pcPlus4E,
  output logic              regWriteE,
  output logic              memToRegE,
  output logic              memReadE,
  output logic              memWriteE,
  output logic              aluSrcE,
  output logic              regDstE,
  output logic [3:0]        aluOpE,
  output logic              validE,
  output logic [4:0]        writeRegE,
  output logic              stallD,
  output logic [CNT_W-1:0]  bubbleCount
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic              regWrite;
    logic              memToReg;
    logic              memRead;
    logic              memWrite;
    logic              aluSrc;
    logic              regDst;
    logic [3:0]        aluOp;
  } exRegT;

  exRegT exQ, exD;
  logic  loadUse;

  always_comb begin
    exD          = '0;
    exD.valid    = validD;
    exD.rs       = rsD;
    exD.rt       = rtD;
    exD.rd       = rdD;
    exD.rd1      = readData1D;
    exD.rd2      = readData2D;
    exD.imm      = immD;
    exD.pc4      = pcPlus4D;
    exD.regWrite = regWriteD;
    exD.memToReg = memToRegD;
    exD.memRead  = memReadD;
    exD.memWrite = memWriteD;
    exD.aluSrc   = aluSrcD;
    exD.regDst   = regDstD;
    exD.aluOp    = aluOpD;
  end

  // Load in E whose destination is consumed by the real instruction in D.
  assign loadUse = exQ.valid & exQ.memRead & exQ.regWrite & (exQ.rt != 5'd0) &
                   validD & ((exQ.rt == rsD) | (exQ.rt == rtD));
  assign stallD  = holdE | (loadUse & ~flushE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exQ         <= '0;
      bubbleCount <= '0;
    end else if (flushE) begin
      exQ <= '0;
    end else if (holdE) begin
      exQ <= exQ;
    end else if (loadUse) begin
      exQ <= '0;
      if (bubbleCount != '1) bubbleCount <= bubbleCount + 1'b1;
    end else begin
      exQ <= exD;
    end
  end

  assign validE     = exQ.valid;
  assign rsE        = exQ.rs;
  assign rtE        = exQ.rt;
  assign rdE        = exQ.rd;
  assign readData1E = exQ.rd1;
  assign readData2E = exQ.rd2;
  assign immE       = exQ.imm;
  assign pcPlus4E   = exQ.pc4;
  assign regWriteE  = exQ.regWrite;
  assign memToRegE  = exQ.memToReg;
  assign memReadE   = exQ.memRead;
  assign memWriteE  = exQ.memWrite;
  assign aluSrcE    = exQ.aluSrc;
  assign regDstE    = exQ.regDst;
  assign aluOpE     = exQ.aluOp;
  assign writeRegE  = exQ.regDst ? exQ.rd : exQ.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use, flush/hold priority,
// counter saturation (CNT_W=2) and asynchronous reset.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic validD;
  logic [4:0] rsD, rtD, rdD;
  logic [DATA_W-1:0] readData1D, readData2D, immD, pcPlus4D;
  logic regWriteD, memToRegD, memReadD, memWriteD, aluSrcD, regDstD;
  logic [3:0] aluOpD;
  logic flushE, holdE;
  logic [4:0] rsE, rtE, rdE, writeRegE;
  logic [DATA_W-1:0] readData1E, readData2E, immE, pcPlus4E;
  logic regWriteE, memToRegE, memReadE, memWriteE, aluSrcE, regDstE, validE, stallD;
  logic [3:0] aluOpE;
  logic [CNT_W-1:0] bubbleCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .validD(validD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .readData1D(readData1D), .readData2D(readData2D), .immD(immD), .pcPlus4D(pcPlus4D),
    .regWriteD(regWriteD), .memToRegD(memToRegD), .memReadD(memReadD),
    .memWriteD(memWriteD), .aluSrcD(aluSrcD), .regDstD(regDstD), .aluOpD(aluOpD),
    .flushE(flushE), .holdE(holdE), .rsE(rsE), .rtE(rtE), .rdE(rdE),
    .readData1E(readData1E), .readData2E(readData2E), .immE(immE), .pcPlus4E(pcPlus4E),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memReadE(memReadE),
    .memWriteE(memWriteE), .aluSrcE(aluSrcE), .regDstE(regDstE), .aluOpE(aluOpE),
    .validE(validE), .writeRegE(writeRegE), .stallD(stallD), .bubbleCount(bubbleCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data fields are derived from the specifiers so captures are easy to recognise.
  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic rdst);
    validD     = v;
    rsD        = rs;
    rtD        = rt;
    rdD        = rd;
    readData1D = 32'hA000_0000 | {27'd0, rs};
    readData2D = 32'hB000_0000 | {27'd0, rt};
    immD       = 32'h0000_00C0 | {27'd0, rd};
    pcPlus4D   = 32'h0000_0400;
    regWriteD  = rw;
    memToRegD  = mr;
    memReadD   = mr;
    memWriteD  = 1'b0;
    aluSrcD    = mr;
    regDstD    = rdst;
    aluOpD     = mr ? 4'h2 : 4'h1;
  endtask

  task automatic lw5();
    drv(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flushE = 1'b0; holdE = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset with random D inputs and running clock
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'($urandom));
      tick();
    end
    chk("rst_validE", validE, 0);
    chk("rst_rsE", rsE, 0);
    chk("rst_rtE", rtE, 0);
    chk("rst_rd1E", readData1E, 0);
    chk("rst_immE", immE, 0);
    chk("rst_ctrl", {regWriteE, memToRegE, memReadE, memWriteE, aluSrcE, regDstE, aluOpE}, 0);
    chk("rst_writeRegE", writeRegE, 0);
    chk("rst_stallD", stallD, 0);
    chk("rst_count", bubbleCount, 0);

    // First capture: add r3 = r1 + r2
    rst = 1'b1;
    drv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("add_rsE", rsE, 1);
    chk("add_rtE", rtE, 2);
    chk("add_writeRegE", writeRegE, 3);
    chk("add_validE", validE, 1);
    chk("add_rd1E", readData1E, 32'hA000_0001);
    chk("add_rd2E", readData2E, 32'hB000_0002);
    chk("add_immE", immE, 32'h0000_00C3);
    chk("add_aluOpE", aluOpE, 1);
    chk("add_stallD", stallD, 0);

    // Load-use: lw r5 in E, add using r5 in D
    lw5();
    tick();
    chk("lw_writeRegE", writeRegE, 5);
    chk("lw_memReadE", memReadE, 1);
    drv(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    #1 chk("lu_stallD", stallD, 1);
    tick();
    chk("lu_bub_validE", validE, 0);
    chk("lu_bub_regWriteE", regWriteE, 0);
    chk("lu_bub_rsE", rsE, 0);
    chk("lu_bub_rd1E", readData1E, 0);
    chk("lu_count", bubbleCount, 1);
    chk("lu_bub_stallD", stallD, 0);
    tick();
    chk("lu_add_rsE", rsE, 5);
    chk("lu_add_validE", validE, 1);
    chk("lu_add_writeRegE", writeRegE, 7);
    chk("lu_add_count", bubbleCount, 1);

    // No false stall: lw to r0
    drv(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
    #1 chk("nfs_r0_stallD", stallD, 0);
    tick();
    chk("nfs_r0_validE", validE, 1);
    chk("nfs_r0_writeRegE", writeRegE, 8);
    chk("nfs_r0_count", bubbleCount, 1);

    // No false stall: invalid D slot, captured normally with validE=0
    lw5();
    tick();
    drv(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    #1 chk("nfs_inv_stallD", stallD, 0);
    tick();
    chk("nfs_inv_validE", validE, 0);
    chk("nfs_inv_rsE", rsE, 5);
    chk("nfs_inv_count", bubbleCount, 1);

    // No false stall: no specifier match
    lw5();
    tick();
    drv(1'b1, 5'd6, 5'd7, 5'd4, 1'b1, 1'b0, 1'b1);
    #1 chk("nfs_nm_stallD", stallD, 0);
    tick();
    chk("nfs_nm_rsE", rsE, 6);
    chk("nfs_nm_validE", validE, 1);
    chk("nfs_nm_count", bubbleCount, 1);

    // Flush with load-use match
    lw5();
    tick();
    drv(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    flushE = 1'b1;
    #1 chk("fl_lu_stallD", stallD, 0);
    tick();
    flushE = 1'b0;
    chk("fl_lu_validE", validE, 0);
    chk("fl_lu_rsE", rsE, 0);
    chk("fl_lu_count", bubbleCount, 1);

    // Flush with hold
    lw5();
    tick();
    flushE = 1'b1; holdE = 1'b1;
    #1 chk("fl_hd_stallD", stallD, 1);
    tick();
    flushE = 1'b0; holdE = 1'b0;
    chk("fl_hd_validE", validE, 0);
    chk("fl_hd_rtE", rtE, 0);
    chk("fl_hd_rd2E", readData2E, 0);

    // Hold with load-use: retain lw, counter unchanged
    lw5();
    tick();
    drv(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1);
    holdE = 1'b1;
    #1 chk("hd_lu_stallD", stallD, 1);
    tick();
    holdE = 1'b0;
    chk("hd_lu_rtE", rtE, 5);
    chk("hd_lu_memReadE", memReadE, 1);
    chk("hd_lu_count", bubbleCount, 1);
    drv(1'b1, 5'd6, 5'd7, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();

    // Hold for 3 cycles with changing D
    drv(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b1);
    tick();
    holdE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'(12 + i), 5'(16 + i), 5'(24 + i), 1'b0, 1'b0, 1'b0);
      #1 chk("hold_stallD", stallD, 1);
      tick();
      chk("hold_rsE", rsE, 9);
      chk("hold_writeRegE", writeRegE, 11);
      chk("hold_rd1E", readData1E, 32'hA000_0009);
    end
    holdE = 1'b0;
    drv(1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b1);
    tick();
    chk("unhold_rsE", rsE, 20);
    chk("unhold_writeRegE", writeRegE, 22);

    // Clear counter, then five consecutive load-use bubbles
    rst = 1'b0;
    #1 chk("rst2_count", bubbleCount, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lw5();
      tick();
      drv(1'b1, 5'd2, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
      tick();
      chk("sat_validE", validE, 0);
      chk("sat_count", bubbleCount, (i < 3) ? 64'(i + 1) : 64'd3);
    end

    // Asynchronous reset pulse mid-cycle
    tick();
    chk("pre_arst_validE", validE, 1);
    #2 rst = 1'b0;
    #1 chk("arst_validE", validE, 0);
    chk("arst_count", bubbleCount, 0);
    chk("arst_rsE", rsE, 0);
    #1 rst = 1'b1;
    #1 chk("arst_rel_validE", validE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
